// File: rtl/rk8e_databreak.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rk8e_databreak : data-break sequencer between the RK8E disk controller and |
// |                  the memory-address/RAM stage. Optional: DB_FIELD_CARRY_EN |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+

module rk8e_databreak_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int            c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0] c_DEPTH = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wp;
    logic [c_AW-1:0]  r_rp;
    logic [c_AW:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_cnt == c_DEPTH);
    assign empty  = (r_cnt == '0);
    assign w_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
    assign w_push = push & (~full | w_pop);
    assign rdata  = r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= wdata;
    end
endmodule

module rk8e_databreak #(
    parameter int         FIFO_DEPTH = 2,
    parameter logic [4:0] DB0        = 5'd16,
    parameter logic [4:0] DB3        = 5'd19
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  state,
    input  logic        start,
    input  logic        dir,
    input  logic [14:0] start_addr,
    input  logic [11:0] word_count,
    input  logic        abort,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [11:0] din_data,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [11:0] dout_data,
    input  logic [11:0] mem2disk,
    output logic        break_req,
    output logic [14:0] dmaAddr,
    output logic [11:0] disk2mem,
    output logic        to_disk,
    output logic        busy,
    output logic        done,
    output logic        addr_wrap
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_REQ   = 3'd2,
        S_BRK   = 3'd3,
        S_DRAIN = 3'd4,
        S_FIN   = 3'd5
    } fsm_t;

    fsm_t        r_fsm;
    fsm_t        w_fsm_nxt;

    logic [14:0] r_addr;
    logic [12:0] r_count;
    logic        r_dir;
    logic        r_abort_pend;
    logic        r_wrap;
    logic        r_break_req;
    logic [11:0] r_disk2mem;
    logic        r_busy;
    logic        r_done;

    logic        w_load;
    logic        w_step;
    logic        w_abort;
    logic        w_last;
    logic [14:0] w_addr_inc;
    logic        w_wrap_hit;

    logic        w_in_push;
    logic        w_in_pop;
    logic        w_in_full;
    logic        w_in_empty;
    logic        w_in_flush;
    logic [11:0] w_in_head;
    logic        w_out_push;
    logic        w_out_pop;
    logic        w_out_full;
    logic        w_out_empty;

    // Words offered outside a disk->memory transfer are taken and thrown away.
    assign w_in_push  = din_valid & ~w_in_full & r_busy & ~r_dir;
    assign w_in_flush = (r_fsm == S_FIN);
    assign w_out_pop  = dout_ready & ~w_out_empty;
    assign w_in_pop   = w_step & ~r_dir;
    assign w_out_push = w_step & r_dir;

    rk8e_databreak_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(12)) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (w_in_flush),
        .push  (w_in_push),
        .pop   (w_in_pop),
        .wdata (din_data),
        .rdata (w_in_head),
        .full  (w_in_full),
        .empty (w_in_empty)
    );

    rk8e_databreak_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(12)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .push  (w_out_push),
        .pop   (w_out_pop),
        .wdata (mem2disk),
        .rdata (dout_data),
        .full  (w_out_full),
        .empty (w_out_empty)
    );

`ifdef DB_FIELD_CARRY_EN
    assign w_addr_inc = r_addr + 15'd1;
    assign w_wrap_hit = &r_addr;
`else
    assign w_addr_inc = {r_addr[14:12], r_addr[11:0] + 12'd1};
    assign w_wrap_hit = &r_addr[11:0];
`endif

    assign w_abort = abort | r_abort_pend;
    assign w_last  = (r_count == 13'd1) | w_abort;

    always_ff @(posedge clk) begin
        if (!reset) r_fsm <= S_IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        w_load    = 1'b0;
        w_step    = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                if (start) begin
                    w_fsm_nxt = S_ARM;
                    w_load    = 1'b1;
                end
            end
            S_ARM: begin
                if (w_abort)
                    w_fsm_nxt = S_FIN;
                else if (r_dir ? ~w_out_full : ~w_in_empty)
                    w_fsm_nxt = S_REQ;
            end
            S_REQ: begin
                if (state == DB0) w_fsm_nxt = S_BRK;
            end
            S_BRK: begin
                if (state == DB3) begin
                    w_step = 1'b1;
                    if (w_last) w_fsm_nxt = r_dir ? S_DRAIN : S_FIN;
                    else        w_fsm_nxt = S_ARM;
                end
            end
            S_DRAIN: begin
                if (w_out_empty) w_fsm_nxt = S_FIN;
            end
            S_FIN:   w_fsm_nxt = S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr       <= '0;
            r_count      <= '0;
            r_dir        <= 1'b0;
            r_abort_pend <= 1'b0;
            r_wrap       <= 1'b0;
            r_break_req  <= 1'b0;
            r_disk2mem   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done      <= (w_fsm_nxt == S_FIN);
            r_break_req <= (w_fsm_nxt == S_REQ);

            if (w_load) begin
                r_addr       <= start_addr;
                r_count      <= (word_count == 12'd0) ? 13'h1000 : {1'b0, word_count};
                r_dir        <= dir;
                r_wrap       <= 1'b0;
                r_abort_pend <= 1'b0;
                r_busy       <= 1'b1;
            end else begin
                if (r_busy && abort) r_abort_pend <= 1'b1;
                if (w_fsm_nxt == S_FIN) r_busy <= 1'b0;
            end

            // Write data is frozen on entry to REQ and held through the break.
            if (r_fsm == S_ARM && w_fsm_nxt == S_REQ)
                r_disk2mem <= r_dir ? 12'd0 : w_in_head;

            if (w_step) begin
                r_addr  <= w_addr_inc;
                r_count <= r_count - 13'd1;
                if (w_wrap_hit) r_wrap <= 1'b1;
            end
        end
    end

    assign din_ready  = ~w_in_full;
    assign dout_valid = ~w_out_empty;
    assign break_req  = r_break_req;
    assign dmaAddr    = r_addr;
    assign disk2mem   = r_disk2mem;
    assign to_disk    = r_dir;
    assign busy       = r_busy;
    assign done       = r_done;
    assign addr_wrap  = r_wrap;
endmodule

`default_nettype wire

// File: tb/tb_rk8e_databreak.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rk8e_databreak : directed bench for rk8e_databreak, with a simple       |
// |                     sequencer model answering breaks with DB0..DB3.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_rk8e_databreak;
    localparam logic [4:0] c_IDLE = 5'd0;
    localparam logic [4:0] c_DB0  = 5'd16;
    localparam logic [4:0] c_DB1  = 5'd17;
    localparam logic [4:0] c_DB2  = 5'd18;
    localparam logic [4:0] c_DB3  = 5'd19;

`ifdef DB_FIELD_CARRY_EN
    localparam logic [14:0] c_WRAP_ADDR = 15'o30000;
    localparam logic        c_WRAP_FLAG = 1'b0;
    localparam logic [14:0] c_BIG_END   = 15'o10000;
    localparam logic        c_BIG_FLAG  = 1'b0;
`else
    localparam logic [14:0] c_WRAP_ADDR = 15'o20000;
    localparam logic        c_WRAP_FLAG = 1'b1;
    localparam logic [14:0] c_BIG_END   = 15'o00000;
    localparam logic        c_BIG_FLAG  = 1'b1;
`endif

    logic        clk;
    logic        reset;
    logic [4:0]  state;
    logic        start;
    logic        dir;
    logic [14:0] start_addr;
    logic [11:0] word_count;
    logic        abort;
    logic        din_valid;
    logic        din_ready;
    logic [11:0] din_data;
    logic        dout_valid;
    logic        dout_ready;
    logic [11:0] dout_data;
    logic [11:0] mem2disk;
    logic        break_req;
    logic [14:0] dmaAddr;
    logic [11:0] disk2mem;
    logic        to_disk;
    logic        busy;
    logic        done;
    logic        addr_wrap;

    int n_vec;
    int n_err;
    int done_cnt;

    rk8e_databreak #(.FIFO_DEPTH(2), .DB0(c_DB0), .DB3(c_DB3)) dut (
        .clk        (clk),
        .reset      (reset),
        .state      (state),
        .start      (start),
        .dir        (dir),
        .start_addr (start_addr),
        .word_count (word_count),
        .abort      (abort),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .mem2disk   (mem2disk),
        .break_req  (break_req),
        .dmaAddr    (dmaAddr),
        .disk2mem   (disk2mem),
        .to_disk    (to_disk),
        .busy       (busy),
        .done       (done),
        .addr_wrap  (addr_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0o, expected %0o", tag, obs, exp);
        end
    endtask

    task automatic start_xfer(input logic d, input logic [14:0] a, input logic [11:0] c);
        dir = d; start_addr = a; word_count = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_din(input logic [11:0] w);
        int n = 0;
        din_valid = 1'b1; din_data = w;
        while (din_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        din_valid = 1'b0;
        check("din_accept", (n < 100), 1);
    endtask

    task automatic do_break(input string tag, input logic [14:0] exp_addr, input logic [11:0] exp_d2m,
                            input logic exp_dir, input logic [11:0] m2d, input logic abrt);
        int n = 0;
        while (break_req !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check({tag, "_breq"}, break_req, 1);
        check({tag, "_addr"}, dmaAddr, exp_addr);
        check({tag, "_dir"}, to_disk, exp_dir);
        if (!exp_dir) check({tag, "_d2m"}, disk2mem, exp_d2m);
        state = c_DB0;
        @(negedge clk);
        check({tag, "_breq_drop"}, break_req, 0);
        state = c_DB1; abort = abrt;
        @(negedge clk);
        abort = 1'b0; state = c_DB2;
        check({tag, "_addr_hold"}, dmaAddr, exp_addr);
        @(negedge clk);
        state = c_DB3; mem2disk = m2d;
        @(negedge clk);
        state = c_IDLE; mem2disk = 12'd0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy === 1'b1 || done === 1'b1) && n < 200) begin @(negedge clk); n++; end
        check("wait_done", (n < 200), 1);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        logic seen;
        n_vec = 0; n_err = 0; done_cnt = 0;
        reset = 1'b0; state = c_IDLE; start = 1'b0; dir = 1'b0; start_addr = '0;
        word_count = '0; abort = 1'b0; din_valid = 1'b0; din_data = '0;
        dout_ready = 1'b0; mem2disk = '0;
        repeat (3) @(negedge clk);

        check("rst_breq", break_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", dmaAddr, 0);
        check("rst_d2m", disk2mem, 0);
        check("rst_todisk", to_disk, 0);
        check("rst_wrap", addr_wrap, 0);
        check("rst_dv", dout_valid, 0);
        reset = 1'b1;
        @(negedge clk);

        // disk->memory, three words
        d0 = done_cnt;
        start_xfer(1'b0, 15'o10200, 12'd3);
        check("wr_busy_on", busy, 1);
        for (int i = 0; i < 3; i++) begin
            send_din(12'(i + 1));
            do_break("wr", 15'o10200 + 15'(i), 12'(i + 1), 1'b0, 12'd0, 1'b0);
            if (i == 0) begin
                start = 1'b1; dir = 1'b1; start_addr = 15'o77777;
                @(negedge clk);
                start = 1'b0; dir = 1'b0;
            end
        end
        wait_done();
        check("wr_done_once", done_cnt - d0, 1);
        check("wr_busy_off", busy, 0);
        check("wr_addr_end", dmaAddr, 15'o10203);

        // memory->disk, two words held back by dout_ready=0
        d0 = done_cnt;
        dout_ready = 1'b0;
        start_xfer(1'b1, 15'o00100, 12'd2);
        do_break("rd0", 15'o00100, 12'd0, 1'b1, 12'o4321, 1'b0);
        do_break("rd1", 15'o00101, 12'd0, 1'b1, 12'o1234, 1'b0);
        repeat (4) @(negedge clk);
        check("rd_busy_drain", busy, 1);
        check("rd_no_early_done", done_cnt - d0, 0);
        check("rd_dv", dout_valid, 1);
        check("rd_head0", dout_data, 12'o4321);
        dout_ready = 1'b1;
        @(negedge clk);
        check("rd_head1", dout_data, 12'o1234);
        @(negedge clk);
        dout_ready = 1'b0;
        check("rd_empty", dout_valid, 0);
        wait_done();
        check("rd_done_once", done_cnt - d0, 1);
        check("rd_busy_off", busy, 0);

        // address wrap at the top of a field
        d0 = done_cnt;
        start_xfer(1'b0, 15'o27777, 12'd2);
        send_din(12'o0005);
        do_break("wp0", 15'o27777, 12'o0005, 1'b0, 12'd0, 1'b0);
        send_din(12'o0006);
        do_break("wp1", c_WRAP_ADDR, 12'o0006, 1'b0, 12'd0, 1'b0);
        wait_done();
        check("wp_done_once", done_cnt - d0, 1);
        check("wp_flag", addr_wrap, c_WRAP_FLAG);

        // abort raised during the fourth break
        d0 = done_cnt;
        start_xfer(1'b0, 15'o00400, 12'd10);
        check("ab_wrap_cleared", addr_wrap, 0);
        for (int i = 0; i < 4; i++) begin
            send_din(12'(i + 8));
            do_break("ab", 15'o00400 + 15'(i), 12'(i + 8), 1'b0, 12'd0, (i == 3));
        end
        wait_done();
        check("ab_done_once", done_cnt - d0, 1);
        check("ab_addr", dmaAddr, 15'o00404);
        check("ab_busy_off", busy, 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (break_req === 1'b1) seen = 1'b1;
        end
        check("ab_no_more_breq", seen, 0);

        // reset while a break is requested and the input buffer is full
        start_xfer(1'b0, 15'o01000, 12'd5);
        send_din(12'o1111);
        send_din(12'o2222);
        check("rs_breq_pre", break_req, 1);
        check("rs_full", din_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rs_breq", break_req, 0);
        check("rs_busy", busy, 0);
        check("rs_din_ready", din_ready, 1);
        check("rs_dv", dout_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        d0 = done_cnt;
        start_xfer(1'b0, 15'o00010, 12'd1);
        send_din(12'o7070);
        do_break("rs_new", 15'o00010, 12'o7070, 1'b0, 12'd0, 1'b0);
        wait_done();
        check("rs_done_once", done_cnt - d0, 1);

        // word_count 0 moves a full 4096 words
        d0 = done_cnt;
        start_xfer(1'b0, 15'o00000, 12'd0);
        for (int i = 0; i < 4096; i++) begin
            send_din(12'(i));
            do_break("big", 15'(i), 12'(i), 1'b0, 12'd0, 1'b0);
            if (i == 4094) check("big_not_done_early", done_cnt - d0, 0);
            if (n_err > 0) break;
        end
        wait_done();
        check("big_done_once", done_cnt - d0, 1);
        check("big_addr_end", dmaAddr, c_BIG_END);
        check("big_wrap", addr_wrap, c_BIG_FLAG);
        check("big_busy_off", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
